// File: rtl/kgp_pkg.sv
// Shared definitions for the instruction-fetch unit: widths, the HALT opcode,
// the fetch FSM state encoding and a word-alignment helper.
package kgp_pkg;

  localparam int PC_W    = 32;
  localparam int IADDR_W = 10;
  localparam int INSTR_W = 32;
  localparam int OPC_W   = 6;
  localparam int FUNC_W  = 5;
  localparam int OFF_W   = 16;

  localparam logic [OPC_W-1:0] OP_HALT = 6'b111111;

  // Clears the two byte-offset bits so every PC is a word address.
  localparam logic [PC_W-1:0] PC_ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  // Truncates a byte address down to the enclosing word.
  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit (master) and its environment (slave):
// instruction-memory read port, execute-stage feedback and the IR outputs.
interface instr_fetch_if;
  import kgp_pkg::*;

  // instruction memory
  logic                      imem_en;
  logic [IADDR_W-1:0]        imem_addr;
  logic [INSTR_W-1:0]        imem_rdata;

  // execute-stage feedback
  logic                      ex_done;
  logic                      branch_taken;
  logic signed [OFF_W-1:0]   br_offset;
  logic                      jump;
  logic [PC_W-1:0]           jump_target;

  // instruction register and status
  logic [INSTR_W-1:0]        instr;
  logic [OPC_W-1:0]          opcode;
  logic [FUNC_W-1:0]         func;
  logic                      instr_valid;
  logic [PC_W-1:0]           pc;
  logic                      halted;

  modport master (
    output imem_en, imem_addr, instr, opcode, func, instr_valid, pc, halted,
    input  imem_rdata, ex_done, branch_taken, br_offset, jump, jump_target
  );

  modport slave (
    input  imem_en, imem_addr, instr, opcode, func, instr_valid, pc, halted,
    output imem_rdata, ex_done, branch_taken, br_offset, jump, jump_target
  );

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection: absolute jump, PC-relative branch or sequential step.
// Purely combinational; all arithmetic wraps modulo 2^PC_W and the result
// is forced to a word boundary.
module pc_next
  import kgp_pkg::*;
(
  input  logic [PC_W-1:0]         pc_i,
  input  logic                    jump_i,
  input  logic                    branch_taken_i,
  input  logic signed [OFF_W-1:0] br_offset_i,
  input  logic [PC_W-1:0]         jump_target_i,
  output logic [PC_W-1:0]         next_pc_o
);

  logic [PC_W-1:0]        seq_pc;
  logic signed [PC_W-1:0] br_disp;
  logic [PC_W-1:0]        br_pc;
  logic [PC_W-1:0]        raw_pc;

  // Word offset sign-extended and scaled to bytes (<<2).
  assign br_disp = {{(PC_W-OFF_W-2){br_offset_i[OFF_W-1]}}, br_offset_i, 2'b00};
  assign seq_pc  = pc_i + PC_W'(4);
  assign br_pc   = seq_pc + $unsigned(br_disp);

  // Jump outranks a taken branch when both are reported together.
  always_comb begin
    raw_pc = seq_pc;
    if (jump_i) begin
      raw_pc = jump_target_i;
    end else if (branch_taken_i) begin
      raw_pc = br_pc;
    end
  end

  assign next_pc_o = align_word(raw_pc);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: a Moore FSM (IDLE, FETCH, WAIT, ISSUE, HALT) that
// reads one word from instruction memory, holds it in IR until the execute
// stage reports completion, then advances the PC (sequential, branch or
// jump). A HALT opcode in IR parks the unit until reset.
module instr_fetch
  import kgp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  fetch_state_e          state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic [PC_W-1:0]       pc_nxt;
  logic                  ir_is_halt;

  pc_next u_pc_next (
    .pc_i           (pc_q),
    .jump_i         (bus.jump),
    .branch_taken_i (bus.branch_taken),
    .br_offset_i    (bus.br_offset),
    .jump_target_i  (bus.jump_target),
    .next_pc_o      (pc_nxt)
  );

  assign ir_is_halt = (ir_q[INSTR_W-1 -: OPC_W] == OP_HALT);

  // State, PC and IR registers; reset discards any in-flight fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, next-PC/IR and Moore outputs decoded from the current state.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ir_d            = ir_q;
    bus.imem_en     = 1'b0;
    bus.instr_valid = 1'b0;
    bus.halted      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        bus.imem_en = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // Memory data is valid in this cycle only; capture it into IR.
        ir_d    = bus.imem_rdata;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.instr_valid = 1'b1;
        // HALT wins over a completion report for the same instruction.
        if (ir_is_halt) begin
          state_d = ST_HALT;
        end else if (bus.ex_done) begin
          pc_d    = pc_nxt;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        bus.halted = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.imem_addr = pc_q[IADDR_W+1:2];
  assign bus.pc        = pc_q;
  assign bus.instr     = ir_q;
  assign bus.opcode    = ir_q[INSTR_W-1 -: OPC_W];
  assign bus.func      = ir_q[FUNC_W-1:0];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port: clk  input  1  single clock for all state; rising-edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: imem_en  output  1  instruction-memory read enable.
REQ-004 SHALL have port: imem_addr  output  10  word address, equal to pc[11:2].
REQ-005 SHALL have port: imem_rdata  input  32  instruction word, valid exactly one cycle after imem_en.
REQ-006 SHALL have port: ex_done  input  1  execute stage has finished the issued instruction.
REQ-007 SHALL have port: branch_taken  input  1  conditional branch resolved taken; sampled with ex_done.
REQ-008 SHALL have port: br_offset  input  16  signed word offset for a taken branch.
REQ-009 SHALL have port: jump  input  1  absolute jump; sampled with ex_done.
REQ-010 SHALL have port: jump_target  input  32  absolute jump byte address.
REQ-011 SHALL have port: instr  output  32  instruction register (IR).
REQ-012 SHALL have port: opcode  output  6  IR[31:26], feeds the control unit.
REQ-013 SHALL have port: func  output  5  IR[4:0], feeds the control unit.
REQ-014 SHALL have port: instr_valid  output  1  IR holds an instruction awaiting execution.
REQ-015 SHALL have port: pc  output  32  byte address of the instruction in IR.
REQ-016 SHALL have port: halted  output  1  HALT instruction reached.

Function
REQ-017 SHALL implement a Moore FSM with states IDLE, FETCH, WAIT, ISSUE, HALT.
REQ-018 SHALL transition IDLE->FETCH on the first clock edge after reset release.
REQ-019 SHALL assert imem_en only in FETCH; FETCH->WAIT unconditionally.
REQ-020 SHALL load IR from imem_rdata on the WAIT->ISSUE edge.
REQ-021 SHALL assert instr_valid only in ISSUE; worst-case first-instruction latency is 3 edges after reset release.
REQ-022 SHALL hold IR, pc, opcode and func stable throughout ISSUE.
REQ-023 SHALL ignore ex_done, branch_taken and jump in every state except ISSUE.
REQ-024 SHALL, in ISSUE with ex_done=1, update pc and go to FETCH: jump=1 -> jump_target; else branch_taken=1 -> pc+4+(sign-extended br_offset<<2); else pc+4.
REQ-025 SHALL give jump priority over branch_taken when both are asserted.
REQ-026 SHALL force next-pc bits [1:0] to 00 (misaligned targets are truncated).
REQ-027 SHALL compute all PC arithmetic modulo 2^32 (0xFFFFFFFC+4 wraps to 0x00000000).
REQ-028 SHALL, in ISSUE when opcode equals OP_HALT (6'b111111), go to HALT on the next edge regardless of ex_done.
REQ-029 SHALL keep HALT until reset, with halted=1, imem_en=0 and instr_valid=0.
REQ-030 SHALL drive opcode and func combinationally from IR.

Reset
REQ-031 SHALL, while rst=0, hold state=IDLE, pc=0, instr=0, instr_valid=0, imem_en=0 and halted=0.
REQ-032 SHALL discard any in-flight fetch when reset asserts mid-operation; the first fetch after release is from address 0.

Structure
REQ-033 SHALL take OP_HALT, the FSM state encoding, and the widths PC_W=32, IADDR_W=10 and INSTR_W=32 from the shared package kgp_pkg.
REQ-034 SHALL place next-PC selection and adders in one sub-module, pc_next (combinational, no state).

Verification
REQ-035 SHALL cover: reset release, memory returns 0x00000000 -> imem_en on edge 1, instr_valid on edge 3, pc=0, opcode=000000.
REQ-036 SHALL cover: sequential run, ex_done pulses with no branch/jump -> imem_addr steps 0,1,2; pc steps 0x0,0x4,0x8.
REQ-037 SHALL cover: pc=0x10, branch_taken=1, br_offset=-2 -> next pc=0x0C; with br_offset=+3 -> next pc=0x20.
REQ-038 SHALL cover: jump=1 with branch_taken=1, jump_target=0x47 -> next pc=0x44 (jump priority, alignment).
REQ-039 SHALL cover: IR opcode 111111 in ISSUE -> halted=1 one edge later; further ex_done has no effect.
REQ-040 SHALL cover: rst asserted during WAIT -> outputs at reset values immediately, without a clock edge; refetch starts at 0.
